// File: rtl/la_cmd_sequencer.sv
// la_cmd_sequencer: LA-port command sequencer driving a counter datapath.
// Firmware posts an opcode/operand pair and flips cmd_toggle. The block runs
// the command, then echoes the toggle on ack_toggle. Status and result are
// returned on la_data_out. The checkbit field goes to io[31:16].
module la_cmd_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic         clock,
  input  logic         resetb,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic [15:0]  chk_out,
  output logic [15:0]  chk_oeb
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RUN
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_LOAD    = 4'd1,
    OP_RUN     = 4'd2,
    OP_READ    = 4'd3,
    OP_SET_CHK = 4'd4,
    OP_CLEAR   = 4'd5
  } opcode_e;

  state_e           state;
  opcode_e          op_q;
  logic [31:0]      operand_q;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] result;
  logic [31:0]      remaining;
  logic             busy;
  logic             err;
  logic             ovf;
  logic             last_toggle;
  logic             ack_toggle;

  logic             cmd_new;
  logic             abort_req;
  logic             unused_inputs;

  // Decode the handshake inputs. A disabled LA bit never counts as asserted.
  always_comb begin
    cmd_new   = 1'b0;
    abort_req = 1'b0;
    if (!la_oenb[64] && (la_data_in[64] != last_toggle)) begin
      cmd_new = 1'b1;
    end
    if (!la_oenb[65] && la_data_in[65]) begin
      abort_req = 1'b1;
    end
  end

  // Upper LA lanes and the remaining output enables carry nothing for this block.
  assign unused_inputs = ^{la_data_in[127:66], la_data_in[63:36],
                           la_oenb[127:66], la_oenb[63:0]};

  // Control FSM and datapath. Any completion clears busy, echoes the toggle,
  // and returns to IDLE on the same edge.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state       <= ST_IDLE;
      op_q        <= OP_NOP;
      operand_q   <= '0;
      counter     <= '0;
      result      <= '0;
      remaining   <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
      ovf         <= 1'b0;
      last_toggle <= 1'b0;
      ack_toggle  <= 1'b0;
      chk_out     <= 16'h0000;
      chk_oeb     <= 16'hFFFF;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_new) begin
            op_q        <= opcode_e'(la_data_in[35:32]);
            operand_q   <= la_data_in[31:0];
            last_toggle <= la_data_in[64];
            busy        <= 1'b1;
            state       <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          busy       <= 1'b0;
          ack_toggle <= last_toggle;
          state      <= ST_IDLE;
          case (op_q)
            OP_NOP: begin
            end
            OP_LOAD: begin
              counter <= operand_q[CNT_W-1:0];
            end
            OP_RUN: begin
              remaining <= operand_q;
              if (operand_q != 32'd0) begin
                busy       <= 1'b1;
                ack_toggle <= ack_toggle;
                state      <= ST_RUN;
              end
            end
            OP_READ: begin
              result <= counter;
            end
            OP_SET_CHK: begin
              chk_out <= operand_q[15:0];
              chk_oeb <= 16'h0000;
            end
            OP_CLEAR: begin
              counter <= '0;
              result  <= '0;
              err     <= 1'b0;
              ovf     <= 1'b0;
            end
            default: begin
              err <= 1'b1;
            end
          endcase
        end

        ST_RUN: begin
          if (abort_req) begin
            busy       <= 1'b0;
            ack_toggle <= last_toggle;
            state      <= ST_IDLE;
          end else begin
            counter   <= counter + 1'b1;
            remaining <= remaining - 32'd1;
            if (&counter) begin
              ovf <= 1'b1;
            end
            if (remaining == 32'd1) begin
              busy       <= 1'b0;
              ack_toggle <= last_toggle;
              state      <= ST_IDLE;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pack registered status onto the LA return lanes. Unassigned lanes stay zero.
  always_comb begin
    la_data_out            = '0;
    la_data_out[CNT_W-1:0] = result;
    la_data_out[32]        = busy;
    la_data_out[33]        = err;
    la_data_out[34]        = ovf;
    la_data_out[64]        = ack_toggle;
  end

endmodule

// File: tb/tb_la_cmd_sequencer.sv
// tb_la_cmd_sequencer: directed tests for the LA command sequencer.
module tb_la_cmd_sequencer;

  logic         clock;
  logic         resetb;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;
  logic [15:0]  chk_out;
  logic [15:0]  chk_oeb;

  int   n_cmp;
  int   n_fail;
  logic tog;
  int   edges;

  la_cmd_sequencer #(.CNT_W(32)) dut (
    .clock       (clock),
    .resetb      (resetb),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out),
    .chk_out     (chk_out),
    .chk_oeb     (chk_oeb)
  );

  // 100 MHz free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Post a command on a falling edge by flipping the toggle
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] operand);
    @(negedge clock);
    la_data_in[35:32] = op;
    la_data_in[31:0]  = operand;
    tog               = ~tog;
    la_data_in[64]    = tog;
  endtask

  // Count edges until ack matches the posted toggle, bounded by max_edges
  task automatic wait_ack(input int max_edges, output int n);
    n = 0;
    do begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end while ((la_data_out[64] !== tog) && (n < max_edges));
  endtask

  task automatic test_reset();
    logic seen_busy;
    resetb     = 1'b0;
    la_data_in = '0;
    la_oenb    = '1;
    la_oenb[64] = 1'b0;
    la_oenb[65] = 1'b0;
    tog        = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (la_data_out !== 128'd0) begin
      n_fail++; $display("[TB] FAIL reset_la_data_out: got %h expected 0", la_data_out);
    end
    n_cmp++;
    if (chk_oeb !== 16'hFFFF) begin
      n_fail++; $display("[TB] FAIL reset_chk_oeb: got %h expected ffff", chk_oeb);
    end
    n_cmp++;
    if (chk_out !== 16'h0000) begin
      n_fail++; $display("[TB] FAIL reset_chk_out: got %h expected 0000", chk_out);
    end
    resetb         = 1'b1;
    la_oenb[64]    = 1'b1;
    la_data_in[64] = 1'b1;
    seen_busy      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (la_data_out[32] !== 1'b0) seen_busy = 1'b1;
    end
    n_cmp++;
    if (seen_busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL gated_toggle_busy: got 1 expected 0");
    end
    n_cmp++;
    if (la_data_out[64] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL gated_toggle_ack: got %b expected 0", la_data_out[64]);
    end
    la_data_in[64] = 1'b0;
    la_oenb[64]    = 1'b0;
  endtask

  task automatic test_set_chk();
    applyStimulus(4'd4, 32'h0000AB40);
    @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (la_data_out[32] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL setchk_busy_k: got %b expected 1", la_data_out[32]);
    end
    @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (la_data_out[64] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL setchk_ack: got %b expected 1", la_data_out[64]);
    end
    n_cmp++;
    if (chk_out !== 16'hAB40) begin
      n_fail++; $display("[TB] FAIL setchk_chk_out: got %h expected ab40", chk_out);
    end
    n_cmp++;
    if (chk_oeb !== 16'h0000) begin
      n_fail++; $display("[TB] FAIL setchk_chk_oeb: got %h expected 0000", chk_oeb);
    end
    applyStimulus(4'd4, 32'h0000AB41);
    wait_ack(20, edges);
    n_cmp++;
    if (chk_out !== 16'hAB41) begin
      n_fail++; $display("[TB] FAIL setchk2_chk_out: got %h expected ab41", chk_out);
    end
    n_cmp++;
    if (la_data_out[64] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL setchk2_ack: got %b expected 0", la_data_out[64]);
    end
  endtask

  task automatic test_load_run_read();
    applyStimulus(4'd1, 32'd100);
    wait_ack(20, edges);
    applyStimulus(4'd2, 32'd5);
    wait_ack(50, edges);
    n_cmp++;
    if (edges !== 7) begin
      n_fail++; $display("[TB] FAIL run5_ack_edges: got %0d expected 7", edges);
    end
    n_cmp++;
    if (la_data_out[31:0] !== 32'd0) begin
      n_fail++; $display("[TB] FAIL run_result_unchanged: got %0d expected 0", la_data_out[31:0]);
    end
    applyStimulus(4'd3, 32'd0);
    wait_ack(20, edges);
    n_cmp++;
    if (la_data_out[31:0] !== 32'd105) begin
      n_fail++; $display("[TB] FAIL read_result: got %0d expected 105", la_data_out[31:0]);
    end
    n_cmp++;
    if (la_data_out[32] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL read_busy: got %b expected 0", la_data_out[32]);
    end
    n_cmp++;
    if (la_data_out[33] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL read_err: got %b expected 0", la_data_out[33]);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(4'd1, 32'hFFFFFFFE);
    wait_ack(20, edges);
    applyStimulus(4'd2, 32'd3);
    wait_ack(20, edges);
    applyStimulus(4'd3, 32'd0);
    wait_ack(20, edges);
    n_cmp++;
    if (la_data_out[31:0] !== 32'd1) begin
      n_fail++; $display("[TB] FAIL wrap_result: got %0d expected 1", la_data_out[31:0]);
    end
    n_cmp++;
    if (la_data_out[34] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL wrap_ovf: got %b expected 1", la_data_out[34]);
    end
    applyStimulus(4'd5, 32'd0);
    wait_ack(20, edges);
    n_cmp++;
    if (la_data_out[31:0] !== 32'd0) begin
      n_fail++; $display("[TB] FAIL clear_result: got %0d expected 0", la_data_out[31:0]);
    end
    n_cmp++;
    if (la_data_out[34] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL clear_ovf: got %b expected 0", la_data_out[34]);
    end
    n_cmp++;
    if (chk_out !== 16'hAB41) begin
      n_fail++; $display("[TB] FAIL clear_keeps_chk_out: got %h expected ab41", chk_out);
    end
    n_cmp++;
    if (chk_oeb !== 16'h0000) begin
      n_fail++; $display("[TB] FAIL clear_keeps_chk_oeb: got %h expected 0000", chk_oeb);
    end
  endtask

  task automatic test_abort();
    applyStimulus(4'd1, 32'd0);
    wait_ack(20, edges);
    applyStimulus(4'd2, 32'd1000);
    repeat (12) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (la_data_out[32] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL abort_busy_before: got %b expected 1", la_data_out[32]);
    end
    la_data_in[65] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    la_data_in[65] = 1'b0;
    n_cmp++;
    if (la_data_out[64] !== tog || la_data_out[32] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_ack: got ack=%b busy=%b expected ack=%b busy=0",
                         la_data_out[64], la_data_out[32], tog);
    end
    applyStimulus(4'd3, 32'd0);
    wait_ack(20, edges);
    n_cmp++;
    if (la_data_out[31:0] !== 32'd10) begin
      n_fail++; $display("[TB] FAIL abort_result: got %0d expected 10", la_data_out[31:0]);
    end
    n_cmp++;
    if (la_data_out[33] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_err: got %b expected 0", la_data_out[33]);
    end
  endtask

  task automatic test_illegal();
    applyStimulus(4'd9, 32'd0);
    wait_ack(20, edges);
    n_cmp++;
    if (edges !== 2) begin
      n_fail++; $display("[TB] FAIL illegal_ack_edges: got %0d expected 2", edges);
    end
    n_cmp++;
    if (la_data_out[33] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL illegal_err: got %b expected 1", la_data_out[33]);
    end
    n_cmp++;
    if (la_data_out[31:0] !== 32'd10) begin
      n_fail++; $display("[TB] FAIL illegal_result_kept: got %0d expected 10", la_data_out[31:0]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic seen_activity;
    applyStimulus(4'd2, 32'd50);
    repeat (10) @(posedge clock);
    @(negedge clock);
    resetb = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (la_data_out !== 128'd0) begin
      n_fail++; $display("[TB] FAIL midrun_reset_la_data_out: got %h expected 0", la_data_out);
    end
    n_cmp++;
    if (chk_oeb !== 16'hFFFF) begin
      n_fail++; $display("[TB] FAIL midrun_reset_chk_oeb: got %h expected ffff", chk_oeb);
    end
    n_cmp++;
    if (chk_out !== 16'h0000) begin
      n_fail++; $display("[TB] FAIL midrun_reset_chk_out: got %h expected 0000", chk_out);
    end
    tog            = 1'b0;
    la_data_in[64] = 1'b0;
    resetb         = 1'b1;
    seen_activity  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (la_data_out !== 128'd0) seen_activity = 1'b1;
    end
    n_cmp++;
    if (seen_activity !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midrun_dropped_no_ack: got activity expected none");
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_set_chk();
    test_load_run_read();
    test_wrap();
    test_abort();
    test_illegal();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
